gama_calc: RTL and testbench

Branch-metric (gamma) generator for the MAP decoder, directly upstream of the gamma SRAM. It accepts one received trellis step at a time (systematic LLR, parity LLR, a-priori LLR) and computes the four branch metrics for the hypotheses (u,p) ∈ {±1}². It then drives the SRAM write port (data, address, write/read select) for four consecutive cycles per step. When idle it hands the SRAM address port to the downstream alpha/beta recursion through a read-address pass-through.

---
 rtl/gama_calc.sv | 140 ++++++++++++++
 tb/tb_gama_calc.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gama_calc.sv
// Gamma branch-metric generator: one trellis step in, four metrics written to the gamma SRAM.
// Optional macro GAMA_SAT_EN: saturate metrics to 16 bits instead of two's-complement wrap.
module gama_calc #(
  parameter int N_STEPS   = 2,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] ys,
  input  logic [15:0] yp,
  input  logic [15:0] la,
  input  logic [7:0]  rd_addr,
  output logic [15:0] g,
  output logic [7:0]  gama_addr,
  output logic        w_r,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_t;

  localparam logic [5:0] LAST_K = 6'(N_STEPS - 1);
  localparam logic [7:0] BASE8  = 8'(BASE_ADDR);

  state_t             state_q;
  logic [5:0]         k_q;
  logic [1:0]         j_q;
  logic signed [16:0] s_q;
  logic signed [15:0] yp_q;
  logic               in_ready_q;
  logic               w_r_q;
  logic               busy_q;
  logic               done_q;
  logic [15:0]        g_q;
  logic [7:0]         addr_q;

  logic signed [17:0] s_ext;
  logic signed [17:0] yp_ext;
  logic signed [17:0] term_u;
  logic signed [17:0] term_p;
  logic [15:0]        g_d;
  logic [7:0]         addr_d;
`ifdef GAMA_SAT_EN
  logic signed [17:0] shf_d;
`endif

  // j[1] negates the systematic term, j[0] negates the parity term
  always_comb begin
    s_ext  = {s_q[16], s_q};
    yp_ext = {{2{yp_q[15]}}, yp_q};
    term_u = j_q[1] ? -s_ext : s_ext;
    term_p = j_q[0] ? -yp_ext : yp_ext;
`ifdef GAMA_SAT_EN
    shf_d = (term_u + term_p) >>> 1;
    if (shf_d > 18'sd32767) begin
      g_d = 16'h7FFF;
    end else if (shf_d < -18'sd32768) begin
      g_d = 16'h8000;
    end else begin
      g_d = shf_d[15:0];
    end
`else
    g_d = 16'((term_u + term_p) >>> 1);
`endif
    addr_d = BASE8 + {k_q, j_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      j_q        <= '0;
      s_q        <= '0;
      yp_q       <= '0;
      in_ready_q <= 1'b0;
      w_r_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      g_q        <= '0;
      addr_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          addr_q <= rd_addr;
          w_r_q  <= 1'b0;
          done_q <= 1'b0;
          if (start) begin
            state_q    <= ST_LOAD;
            k_q        <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          w_r_q <= 1'b0;
          if (in_valid) begin
            s_q        <= {la[15], la} + {ys[15], ys};
            yp_q       <= yp;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          g_q    <= g_d;
          addr_q <= addr_d;
          w_r_q  <= 1'b1;
          j_q    <= j_q + 2'd1;
          if (j_q == 2'd3) begin
            if (k_q < LAST_K) begin
              k_q        <= k_q + 6'd1;
              in_ready_q <= 1'b1;
              state_q    <= ST_LOAD;
            end else begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          w_r_q   <= 1'b0;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign g         = g_q;
  assign gama_addr = addr_q;
  assign w_r       = w_r_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gama_calc.sv
// Self-checking bench for gama_calc: directed and randomized blocks against an arithmetic reference model.
module tb_gama_calc;

  localparam int N_STEPS   = 2;
  localparam int BASE_ADDR = 0;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] ys, yp, la;
  logic [7:0]  rd_addr;
  logic        in_ready, w_r, busy, done;
  logic [15:0] g;
  logic [7:0]  gama_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  logic [7:0]  wq_a[$];
  logic [15:0] wq_d[$];
  int          wq_c[$];
  logic [7:0]  exp_a[$];
  logic [15:0] exp_d[$];

  logic [15:0] sram    [0:255];
  logic [15:0] exp_mem [0:255];
  logic [15:0] gd;

  gama_calc #(.N_STEPS(N_STEPS), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .ys(ys), .yp(yp), .la(la), .rd_addr(rd_addr), .g(g), .gama_addr(gama_addr),
    .w_r(w_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural gamma SRAM: write on w_r, one-cycle registered read
  always @(posedge clk) begin
    if (w_r) sram[gama_addr] <= g;
    gd <= sram[gama_addr];
  end

  always @(negedge clk) begin
    if (w_r) begin
      wq_a.push_back(gama_addr);
      wq_d.push_back(g);
      wq_c.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Metric = floor((u*(la+ys) + p*yp) / 2), then saturated or wrapped to 16 bits
  function automatic logic [15:0] ref_metric(input logic [15:0] vys, vyp, vla, input int j);
    int s, u, p, m, h;
    s = int'($signed(vys)) + int'($signed(vla));
    u = (j >= 2) ? -1 : 1;
    p = (j % 2 == 1) ? -1 : 1;
    m = u * s + p * int'($signed(vyp));
    h = (m >= 0) ? m / 2 : -((1 - m) / 2);
`ifdef GAMA_SAT_EN
    if (h > 32767) h = 32767;
    if (h < -32768) h = -32768;
`endif
    return 16'(h);
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 4))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wq_a.delete(); wq_d.delete(); wq_c.delete();
    exp_a.delete(); exp_d.delete();
    done_cnt = 0;
  endtask

  task automatic expect_step(input int k, input logic [15:0] vys, vyp, vla);
    for (int j = 0; j < 4; j++) begin
      logic [7:0]  a;
      logic [15:0] d;
      a = 8'(BASE_ADDR + 4 * k + j);
      d = ref_metric(vys, vyp, vla, j);
      exp_a.push_back(a);
      exp_d.push_back(d);
      exp_mem[a] = d;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] vys, vyp, vla, output int hc);
    int n;
    ys = vys; yp = vyp; la = vla; in_valid = 1'b1; n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    checks++;
    if (!in_ready) begin
      $display("FAIL feed_timeout in_ready=%b required=1", in_ready);
      errors++;
    end
    tick();
    hc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    checks++;
    if (busy) begin
      $display("FAIL done_timeout busy=%b required=0", busy);
      errors++;
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    ys = '0; yp = '0; la = '0; rd_addr = '0;
    tick(); tick();
    checks++;
    if ({in_ready, g, gama_addr, w_r, busy, done} !== 28'd0) begin
      $display("FAIL reset_outputs got in_ready=%b g=%h addr=%h w_r=%b busy=%b done=%b required all 0",
               in_ready, g, gama_addr, w_r, busy, done);
      errors++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({in_ready, busy, w_r, done, gama_addr} !== 12'd0) begin
      $display("FAIL idle_after_reset got in_ready=%b busy=%b w_r=%b done=%b addr=%h required 0",
               in_ready, busy, w_r, done, gama_addr);
      errors++;
    end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int hc0, hc1;
    clear_q();
    do_start();
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      $display("FAIL start_latency got busy=%b in_ready=%b required 1 1", busy, in_ready);
      errors++;
    end
    feed(16'd100, 16'd40, 16'd20, hc0);
    checks++;
    if (in_ready !== 1'b0) begin
      $display("FAIL in_ready_after_hs got=%b required=0", in_ready);
      errors++;
    end
    expect_step(0, 16'd100, 16'd40, 16'd20);
    feed(16'hFFFA, 16'd10, 16'd0, hc1);
    expect_step(1, 16'hFFFA, 16'd10, 16'd0);
    wait_done();
    checks++;
    if (wq_a.size() != 8) begin
      $display("FAIL basic_count got=%0d required=8", wq_a.size());
      errors++;
    end
    foreach (exp_a[i]) if (i < wq_a.size()) begin
      checks++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        $display("FAIL basic_write[%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                 i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
        errors++;
      end
    end
    if (wq_c.size() == 8) begin
      checks++;
      if (wq_c[0] != hc0 + 1 || wq_c[3] != hc0 + 4 || wq_c[4] != hc1 + 1 || wq_c[7] != hc1 + 4) begin
        $display("FAIL basic_timing got cycles %0d %0d %0d %0d required %0d %0d %0d %0d",
                 wq_c[0], wq_c[3], wq_c[4], wq_c[7], hc0 + 1, hc0 + 4, hc1 + 1, hc1 + 4);
        errors++;
      end
      checks++;
      if (done_cyc != wq_c[7] + 1) begin
        $display("FAIL done_timing got cycle=%0d required=%0d", done_cyc, wq_c[7] + 1);
        errors++;
      end
    end
    checks++;
    if (done_cnt != 1) begin
      $display("FAIL basic_done_count got=%0d required=1", done_cnt);
      errors++;
    end
    $display("test_basic done: %0d writes, done pulses %0d", wq_a.size(), done_cnt);
  endtask

  task automatic test_sat();
    int hc;
    logic [15:0] r0, r1, r2;
    clear_q();
    do_start();
    feed(16'h7FFF, 16'h7FFF, 16'h7FFF, hc);
    expect_step(0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
    feed(r0, r1, r2, hc);
    expect_step(1, r0, r1, r2);
    wait_done();
    checks++;
    if (wq_a.size() != 8) begin
      $display("FAIL sat_count got=%0d required=8", wq_a.size());
      errors++;
    end
    foreach (exp_a[i]) if (i < wq_a.size()) begin
      checks++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        $display("FAIL sat_write[%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                 i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
        errors++;
      end
    end
    if (wq_d.size() >= 4) begin
      checks++;
`ifdef GAMA_SAT_EN
      if (wq_d[0] !== 16'h7FFF || wq_d[3] !== 16'h8000) begin
        $display("FAIL sat_extremes got j0=%0d j3=%0d required 32767 -32768", $signed(wq_d[0]), $signed(wq_d[3]));
        errors++;
      end
`else
      if (wq_d[0] !== 16'hBFFE || wq_d[3] !== 16'h4001) begin
        $display("FAIL wrap_extremes got j0=%0d j3=%0d required -16386 16385", $signed(wq_d[0]), $signed(wq_d[3]));
        errors++;
      end
`endif
    end
    $display("test_sat done: j0=%0d j3=%0d", $signed(wq_d[0]), $signed(wq_d[3]));
  endtask

  task automatic test_stall();
    int hc;
    logic [15:0] r0, r1, r2;
    clear_q();
    do_start();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (w_r !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b1) begin
        $display("FAIL stall_cycle[%0d] got w_r=%b in_ready=%b busy=%b required 0 1 1", i, w_r, in_ready, busy);
        errors++;
      end
    end
    for (int k = 0; k < N_STEPS; k++) begin
      r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
      feed(r0, r1, r2, hc);
      expect_step(k, r0, r1, r2);
    end
    wait_done();
    checks++;
    if (wq_a.size() != exp_a.size() || done_cnt != 1) begin
      $display("FAIL stall_count got writes=%0d done=%0d required %0d 1", wq_a.size(), done_cnt, exp_a.size());
      errors++;
    end
    foreach (exp_a[i]) if (i < wq_a.size()) begin
      checks++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        $display("FAIL stall_write[%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                 i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
        errors++;
      end
    end
    $display("test_stall done: %0d writes", wq_a.size());
  endtask

  task automatic test_start_ignored();
    int hc;
    logic [15:0] r0, r1, r2;
    clear_q();
    do_start();
    r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
    feed(r0, r1, r2, hc);
    expect_step(0, r0, r1, r2);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
    feed(r0, r1, r2, hc);
    expect_step(1, r0, r1, r2);
    wait_done();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (wq_a.size() != exp_a.size() || done_cnt != 1 || busy !== 1'b0) begin
      $display("FAIL start_ignored got writes=%0d done=%0d busy=%b required %0d 1 0",
               wq_a.size(), done_cnt, busy, exp_a.size());
      errors++;
    end
    foreach (exp_a[i]) if (i < wq_a.size()) begin
      checks++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        $display("FAIL start_ignored_write[%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                 i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
        errors++;
      end
    end
    $display("test_start_ignored done: %0d writes, done pulses %0d", wq_a.size(), done_cnt);
  endtask

  task automatic test_reset_mid();
    int hc;
    logic [15:0] r0, r1, r2;
    clear_q();
    do_start();
    feed(rnd16(), rnd16(), rnd16(), hc);
    feed(rnd16(), rnd16(), rnd16(), hc);
    tick();
    tick();
    checks++;
    if (w_r !== 1'b1 || gama_addr !== 8'(BASE_ADDR + 5)) begin
      $display("FAIL reset_mid_position got w_r=%b addr=%0d required 1 %0d", w_r, gama_addr, BASE_ADDR + 5);
      errors++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, g, gama_addr, w_r, busy, done} !== 28'd0) begin
      $display("FAIL reset_mid_outputs got in_ready=%b g=%h addr=%h w_r=%b busy=%b done=%b required all 0",
               in_ready, g, gama_addr, w_r, busy, done);
      errors++;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    clear_q();
    do_start();
    for (int k = 0; k < N_STEPS; k++) begin
      r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
      feed(r0, r1, r2, hc);
      expect_step(k, r0, r1, r2);
    end
    wait_done();
    checks++;
    if (wq_a.size() != exp_a.size() || done_cnt != 1) begin
      $display("FAIL reset_mid_rerun got writes=%0d done=%0d required %0d 1", wq_a.size(), done_cnt, exp_a.size());
      errors++;
    end
    foreach (exp_a[i]) if (i < wq_a.size()) begin
      checks++;
      if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
        $display("FAIL reset_mid_write[%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                 i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
        errors++;
      end
    end
    $display("test_reset_mid done: rerun %0d writes", wq_a.size());
  endtask

  task automatic test_random();
    int hc;
    logic [15:0] r0, r1, r2;
    for (int b = 0; b < 6; b++) begin
      clear_q();
      do_start();
      for (int k = 0; k < N_STEPS; k++) begin
        in_valid = 1'b0;
        for (int s = $urandom_range(0, 3); s > 0; s--) tick();
        r0 = rnd16(); r1 = rnd16(); r2 = rnd16();
        feed(r0, r1, r2, hc);
        expect_step(k, r0, r1, r2);
        // garbage presented during WRITE must not be captured
        ys = 16'($urandom); yp = 16'($urandom); la = 16'($urandom); in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
      end
      wait_done();
      checks++;
      if (wq_a.size() != exp_a.size() || done_cnt != 1) begin
        $display("FAIL random_count[%0d] got writes=%0d done=%0d required %0d 1", b, wq_a.size(), done_cnt, exp_a.size());
        errors++;
      end
      foreach (exp_a[i]) if (i < wq_a.size()) begin
        checks++;
        if (wq_a[i] !== exp_a[i] || wq_d[i] !== exp_d[i]) begin
          $display("FAIL random_write[%0d][%0d] got addr=%0d g=%0d required addr=%0d g=%0d",
                   b, i, wq_a[i], $signed(wq_d[i]), exp_a[i], $signed(exp_d[i]));
          errors++;
        end
      end
      $display("test_random block %0d done: %0d writes", b, wq_a.size());
    end
  endtask

  task automatic test_readback();
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 8'(BASE_ADDR + 5) : 8'(BASE_ADDR + $urandom_range(0, 4 * N_STEPS - 1));
      rd_addr = a;
      tick();
      checks++;
      if (gama_addr !== a || w_r !== 1'b0) begin
        $display("FAIL passthrough[%0d] got addr=%0d w_r=%b required %0d 0", i, gama_addr, w_r, a);
        errors++;
      end
      tick();
      checks++;
      if (gd !== exp_mem[a]) begin
        $display("FAIL readback[%0d] addr=%0d got=%0d required=%0d", i, a, $signed(gd), $signed(exp_mem[a]));
        errors++;
      end
      $display("test_readback addr=%0d data=%0d", a, $signed(gd));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat();
    test_stall();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_readback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
